// File: rtl/qpsk_tx_pkg.sv
// Shared types and constants for the QPSK transmit framer.
package qpsk_tx_pkg;

   typedef logic [1:0] symbol_t;
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_PREAMBLE = 3'd1;
   localparam state_t ST_SYNC     = 3'd2;
   localparam state_t ST_HEADER   = 3'd3;
   localparam state_t ST_PAYLOAD  = 3'd4;

   localparam symbol_t     PREAMBLE_A        = 2'b00;
   localparam symbol_t     PREAMBLE_B        = 2'b11;
   localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hD391;
   localparam int          SYMS_PER_BYTE     = 4;

   function automatic symbol_t next_preamble(input symbol_t cur);
      return (cur == PREAMBLE_A) ? PREAMBLE_B : PREAMBLE_A;
   endfunction

endpackage

// File: rtl/qpsk_symbol_serializer.sv
// MSB-first byte to 2-bit symbol serializer. The caller emits byte_in[7:6] itself on load;
// 'symbol' is always the symbol to emit on the next advance.
module qpsk_symbol_serializer
   import qpsk_tx_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] byte_in,
   input  logic       advance,
   output logic [1:0] symbol,
   output logic       last_symbol
);

   logic [7:0] shreg;
   logic [1:0] idx;

   // Shift register and position of the currently emitted symbol within its byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg <= 8'h00;
         idx   <= 2'd0;
      end else if (load) begin
         shreg <= {byte_in[5:0], 2'b00};
         idx   <= 2'd0;
      end else if (advance) begin
         shreg <= {shreg[5:0], 2'b00};
         idx   <= idx + 2'd1;
      end else begin
         shreg <= shreg;
         idx   <= idx;
      end
   end

   assign symbol      = shreg[7:6];
   assign last_symbol = (idx == 2'(SYMS_PER_BYTE - 1));

endmodule

// File: rtl/qpsk_tx_framer.sv
// Frame sequencer feeding qpsk_modulator: preamble, sync word, length header, payload,
// one symbol per mod_req, with a one-byte prefetch buffer on the payload stream.
module qpsk_tx_framer
   import qpsk_tx_pkg::*;
#(
   parameter int          PREAMBLE_SYMS = 32,
   parameter logic [15:0] SYNC_WORD     = DEFAULT_SYNC_WORD
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] frame_len,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   input  logic       mod_req,
   output logic [1:0] symbol_out,
   output logic       symbol_en,
   output logic       busy,
   output logic       done,
   output logic       underrun
);

   localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_SYMS - 1);

   state_t     state, state_nxt;
   logic [7:0] sym_cnt, cnt_nxt;
   logic [7:0] len_reg, bytes_fetched, bytes_sent, hold_buf, ld_byte;
   logic       hold_full, xfer, ld, shift, finish, abort, take_hold;
   logic [1:0] sym_nxt, ser_symbol;
   logic       ser_last;

   // Ready depends only on registered state, never on byte_valid.
   assign byte_ready = busy && !hold_full && (bytes_fetched < len_reg);
   assign xfer       = byte_valid && byte_ready;

   qpsk_symbol_serializer u_ser (
      .clk         (clk),
      .reset       (reset),
      .load        (ld),
      .byte_in     (ld_byte),
      .advance     (shift),
      .symbol      (ser_symbol),
      .last_symbol (ser_last)
   );

   // Next state, next symbol and serializer control for the current mod_req.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = sym_cnt;
      sym_nxt   = symbol_out;
      ld        = 1'b0;
      ld_byte   = 8'h00;
      shift     = 1'b0;
      finish    = 1'b0;
      abort     = 1'b0;
      take_hold = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_PREAMBLE;
               cnt_nxt   = 8'd0;
               sym_nxt   = PREAMBLE_A;
            end else begin
               sym_nxt = 2'b00;
            end
         end
         ST_PREAMBLE: begin
            if (mod_req) begin
               if (sym_cnt == PRE_LAST) begin
                  state_nxt = ST_SYNC;
                  cnt_nxt   = 8'd0;
                  ld        = 1'b1;
                  ld_byte   = SYNC_WORD[15:8];
                  sym_nxt   = SYNC_WORD[15:14];
               end else begin
                  cnt_nxt = sym_cnt + 8'd1;
                  sym_nxt = next_preamble(symbol_out);
               end
            end else begin
               cnt_nxt = sym_cnt;
            end
         end
         ST_SYNC: begin
            if (mod_req) begin
               if (sym_cnt == 8'd7) begin
                  state_nxt = ST_HEADER;
                  cnt_nxt   = 8'd0;
                  ld        = 1'b1;
                  ld_byte   = len_reg;
                  sym_nxt   = len_reg[7:6];
               end else if (ser_last) begin
                  cnt_nxt = sym_cnt + 8'd1;
                  ld      = 1'b1;
                  ld_byte = SYNC_WORD[7:0];
                  sym_nxt = SYNC_WORD[7:6];
               end else begin
                  cnt_nxt = sym_cnt + 8'd1;
                  shift   = 1'b1;
                  sym_nxt = ser_symbol;
               end
            end else begin
               cnt_nxt = sym_cnt;
            end
         end
         // Header and payload share the byte-boundary rule: next byte, finish, or underrun.
         ST_HEADER, ST_PAYLOAD: begin
            if (mod_req) begin
               if (!ser_last) begin
                  shift   = 1'b1;
                  sym_nxt = ser_symbol;
               end else if (bytes_sent == len_reg) begin
                  finish    = 1'b1;
                  state_nxt = ST_IDLE;
                  sym_nxt   = 2'b00;
               end else if (hold_full) begin
                  state_nxt = ST_PAYLOAD;
                  ld        = 1'b1;
                  ld_byte   = hold_buf;
                  take_hold = 1'b1;
                  sym_nxt   = hold_buf[7:6];
               end else begin
                  abort     = 1'b1;
                  state_nxt = ST_IDLE;
                  sym_nxt   = 2'b00;
               end
            end else begin
               shift = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 8'd0;
            sym_nxt   = 2'b00;
         end
      endcase
   end

   // Sequencer state and registered modulator-facing outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         sym_cnt    <= 8'd0;
         symbol_out <= 2'b00;
         symbol_en  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state      <= state_nxt;
         sym_cnt    <= cnt_nxt;
         symbol_out <= sym_nxt;
         symbol_en  <= (state_nxt != ST_IDLE);
         busy       <= (state_nxt != ST_IDLE);
         done       <= finish;
         underrun   <= abort;
      end
   end

   // Frame length latch, prefetch hold buffer and byte counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_reg       <= 8'd0;
         bytes_fetched <= 8'd0;
         bytes_sent    <= 8'd0;
         hold_buf      <= 8'h00;
         hold_full     <= 1'b0;
      end else if ((state == ST_IDLE) && start) begin
         len_reg       <= frame_len;
         bytes_fetched <= 8'd0;
         bytes_sent    <= 8'd0;
         hold_full     <= 1'b0;
      end else if (xfer) begin
         hold_buf      <= byte_data;
         hold_full     <= 1'b1;
         bytes_fetched <= bytes_fetched + 8'd1;
      end else if (take_hold) begin
         hold_full  <= 1'b0;
         bytes_sent <= bytes_sent + 8'd1;
      end else begin
         hold_full <= hold_full;
      end
   end

endmodule

// File: tb/tb_qpsk_tx_framer.sv
// Scoreboard bench for qpsk_tx_framer: a frame-level model queues expected symbols and end
// events; a monitor pops them on every accepted mod_req / done / underrun.
module tb_qpsk_tx_framer;

   localparam int          PRE  = 4;
   localparam logic [15:0] SYNC = 16'hD391;

   logic       clk = 1'b0;
   logic       reset, start, mod_req, byte_valid, byte_ready;
   logic       symbol_en, busy, done, underrun;
   logic [7:0] frame_len, byte_data;
   logic [1:0] symbol_out;

   always #5 clk = ~clk;

   qpsk_tx_framer #(.PREAMBLE_SYMS(PRE), .SYNC_WORD(SYNC)) dut (
      .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
      .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .mod_req(mod_req), .symbol_out(symbol_out), .symbol_en(symbol_en),
      .busy(busy), .done(done), .underrun(underrun)
   );

   int n_pass = 0, n_total = 0;
   logic [1:0] exp_sym[$];
   int         exp_evt[$];      // 1 = done, 2 = underrun
   logic [7:0] pay_q[$];
   logic [7:0] src_q[$];
   int src_mode = 0, accepted = 0, req_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic void push_byte(input logic [7:0] b);
      for (int k = 0; k < 4; k++) exp_sym.push_back(2'((b >> (6 - 2 * k)) & 8'h03));
   endfunction

   // Expected symbol stream of a whole frame, straight from the frame format.
   function automatic void model_frame(input int len, input int supply);
      for (int i = 0; i < PRE; i++) exp_sym.push_back((i % 2 == 1) ? 2'b11 : 2'b00);
      push_byte(SYNC[15:8]);
      push_byte(SYNC[7:0]);
      push_byte(8'(len));
      for (int i = 0; i < supply && i < len; i++) push_byte(pay_q[i]);
      exp_evt.push_back((supply >= len) ? 1 : 2);
   endfunction

   // Upstream byte source: mode 0 always valid, 1 every other cycle, 2 random.
   initial begin
      bit xfer, phase;
      byte_valid = 1'b0; byte_data = 8'h00; phase = 1'b0;
      forever begin
         @(negedge clk);
         xfer = byte_valid && byte_ready && !reset;
         @(posedge clk);
         if (xfer && !reset && src_q.size() > 0) begin
            void'(src_q.pop_front());
            accepted++;
         end
         #1;
         phase = !phase;
         if (src_q.size() > 0 && (src_mode == 0 || (src_mode == 1 && phase) ||
                                  (src_mode == 2 && $urandom_range(0, 1) == 1))) begin
            byte_valid = 1'b1; byte_data = src_q[0];
         end else begin
            byte_valid = 1'b0; byte_data = 8'($urandom);
         end
      end
   end

   // Monitor: consumes expectations whenever the DUT presents a symbol or an end event.
   initial begin
      logic [1:0] e;
      int ev;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (mod_req && busy) begin
               req_cnt++;
               if (exp_sym.size() == 0) check("extra_symbol_busy", int'(busy), 0);
               else begin
                  e = exp_sym.pop_front();
                  check("symbol", int'(symbol_out), int'(e));
               end
            end
            if (done || underrun) begin
               if (exp_evt.size() == 0) check("unexpected_end_pulse", int'(done) + int'(underrun), 0);
               else begin
                  ev = exp_evt.pop_front();
                  check("done", int'(done), int'(ev == 1));
                  check("underrun", int'(underrun), int'(ev == 2));
                  check("end_symbols_left", exp_sym.size(), 0);
                  check("end_symbol_en", int'(symbol_en), 0);
                  check("end_busy", int'(busy), 0);
                  check("end_symbol_out", int'(symbol_out), 0);
               end
            end
         end
      end
   end

   task automatic run_frame(input int len, input int supply, input int gap, input int mode,
                            input bit with_req, input int restart_at, input int reset_at);
      int n, cyc, budget, ready_seen;
      src_mode = mode; accepted = 0; req_cnt = 0;
      model_frame(len, supply);
      for (int i = 0; i < supply; i++) src_q.push_back(pay_q[i]);
      budget = (PRE + 16 + 4 * len) * gap + 50;
      n = 0; cyc = 0; ready_seen = 0;
      @(posedge clk); #1;
      start = 1'b1; mod_req = with_req; frame_len = 8'(len);
      forever begin
         @(posedge clk); #1;
         start = 1'b0; mod_req = 1'b0; frame_len = 8'($urandom);
         if (!busy) break;
         if (byte_ready) ready_seen++;
         if (reset_at > 0 && n == reset_at) begin
            @(negedge clk); #2;
            reset = 1'b1;
            #1;
            check("async_rst_busy", int'(busy), 0);
            check("async_rst_symbol_en", int'(symbol_en), 0);
            check("async_rst_symbol_out", int'(symbol_out), 0);
            check("async_rst_byte_ready", int'(byte_ready), 0);
            check("async_rst_done", int'(done), 0);
            check("async_rst_underrun", int'(underrun), 0);
            exp_sym.delete(); exp_evt.delete(); src_q.delete();
            @(posedge clk); #1;
            reset = 1'b0;
            return;
         end
         cyc++;
         if (cyc > budget) begin
            check("frame_timeout", int'(busy), 0);
            break;
         end
         if (cyc % gap == 0) begin
            mod_req = 1'b1;
            n++;
            if (n == restart_at) start = 1'b1;
         end
      end
      repeat (3) @(posedge clk);
      check("req_count", req_cnt, PRE + 12 + 4 * ((supply < len) ? supply : len));
      check("bytes_accepted", accepted, supply);
      if (len == 0) check("ready_len0", ready_seen, 0);
      check("left_symbols", exp_sym.size(), 0);
      check("left_events", exp_evt.size(), 0);
      exp_sym.delete(); exp_evt.delete(); src_q.delete();
   endtask

   task automatic fill_random(input int cnt);
      pay_q.delete();
      for (int i = 0; i < cnt; i++) pay_q.push_back(8'($urandom));
   endtask

   initial begin
      int len, supply, gap, mode;
      reset = 1'b1; start = 1'b0; mod_req = 1'b0; frame_len = 8'd0;
      #3;
      check("rst_symbol_out", int'(symbol_out), 0);
      check("rst_symbol_en", int'(symbol_en), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_underrun", int'(underrun), 0);
      check("rst_byte_ready", int'(byte_ready), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      pay_q.delete(); pay_q.push_back(8'hA5); pay_q.push_back(8'h3C);
      run_frame(2, 2, 100, 0, 1'b0, 0, 0);

      pay_q.delete();
      run_frame(0, 0, 3, 0, 1'b0, 0, 0);

      pay_q.delete(); pay_q.push_back(8'h5A); pay_q.push_back(8'h77); pay_q.push_back(8'h01);
      run_frame(3, 1, 2, 0, 1'b0, 0, 0);

      fill_random(2);
      run_frame(2, 2, 3, 1, 1'b1, PRE + 3, 0);

      fill_random(5);
      run_frame(5, 5, 2, 0, 1'b0, 0, PRE + 14);
      pay_q.delete(); pay_q.push_back(8'hFF);
      run_frame(1, 1, 4, 0, 1'b0, 0, 0);

      for (int t = 0; t < 8; t++) begin
         len    = $urandom_range(0, 12);
         supply = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len;
         gap    = $urandom_range(1, 10);
         mode   = (gap >= 8) ? $urandom_range(0, 2) : $urandom_range(0, 1);
         fill_random(len);
         run_frame(len, supply, gap, mode, 1'($urandom_range(0, 1)), 0, 0);
      end

      fill_random(64);
      run_frame(64, 64, 100, 1, 1'b0, 0, 0);

      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/qpsk_tx_framer.md
Name: qpsk_tx_framer

Overview:
Frame sequencer that drives the symbol input of qpsk_modulator. On a start command it emits a fixed preamble, a 16-bit sync word, a 1-byte length header, then frame_len payload bytes. Each byte is serialised MSB-first as four 2-bit QPSK symbols, and the block advances one symbol per modulator mod_req. Payload bytes come from an upstream valid/ready byte stream through a one-byte prefetch buffer.

Parameters:
PREAMBLE_SYMS, 32, number of preamble symbols (even, 2..255); the pattern alternates 2'b00, 2'b11, starting with 2'b00.
SYNC_WORD, 16'hD391, sync word sent MSB-first as 8 symbols.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  frame start pulse; sampled only in IDLE
frame_len  input  8  payload byte count, latched on accepted start; 0 is legal (header only)
byte_data  input  8  payload byte
byte_valid  input  1  byte_data valid
byte_ready  output  1  framer accepts byte_data this cycle
mod_req  input  1  modulator symbol request (one-cycle pulse)
symbol_out  output  2  current symbol, to modulator symbol_in
symbol_en  output  1  to modulator symbol_en; high while a frame is active
busy  output  1  frame in progress
done  output  1  one-cycle pulse when a frame completes
underrun  output  1  one-cycle pulse when a frame is aborted for lack of payload data

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state = IDLE.
  - symbol_out = 2'b00; symbol_en, busy, done, underrun, byte_ready = 0.
  - Prefetch buffer emptied; all counters cleared.
- States and transitions:
  - IDLE -> PREAMBLE -> SYNC -> HEADER -> PAYLOAD -> IDLE.
  - HEADER -> IDLE directly when frame_len = 0.
- Symbol timing:
  - An accepted start in IDLE moves to PREAMBLE. On the next cycle symbol_out = first preamble symbol and symbol_en = busy = 1.
  - Each cycle with mod_req = 1 while busy registers the next symbol, visible the following cycle.
  - symbol_out holds steady between mod_req pulses.
- Symbol counts per state:
  - PREAMBLE: PREAMBLE_SYMS symbols.
  - SYNC: 8 symbols.
  - HEADER: 4 symbols of frame_len.
  - PAYLOAD: 4 × frame_len symbols.
- Completion: the mod_req that consumes the final symbol gives, on the next cycle, state = IDLE, symbol_en = busy = 0, symbol_out = 2'b00, done = 1 for exactly one cycle.
- Prefetch:
  - byte_ready = busy && hold buffer empty && bytes_fetched < frame_len.
  - A transfer occurs when byte_valid && byte_ready. byte_ready is registered-free combinational from state; there is no combinational path from byte_valid to byte_ready.
  - Prefetch is allowed from the first PREAMBLE cycle.
- Byte boundary: on the mod_req consuming the last symbol of the header or of a payload byte, with payload bytes remaining, the hold buffer moves into the shift register.
  - If the hold buffer is empty at that point: underrun = 1 for one cycle, the frame aborts to IDLE (same output values as completion), and done is not asserted.
- Ignored inputs:
  - start while busy is ignored.
  - mod_req in IDLE is ignored.
  - start and mod_req in the same IDLE cycle: start is accepted, mod_req is ignored.
  - byte_valid while byte_ready = 0 is ignored.
- Counters:
  - 8-bit symbol counter within each state.
  - 8-bit bytes_fetched and bytes_sent counters.
  - No wrap: counts are bounded by frame_len ≤ 255.

Decomposition:
- Package qpsk_tx_pkg:
  - State enum.
  - Symbol typedef (logic [1:0]).
  - PREAMBLE_A = 2'b00, PREAMBLE_B = 2'b11.
  - Default SYNC_WORD.
  - SYMS_PER_BYTE = 4.
- Sub-module qpsk_symbol_serializer:
  - Contents: 8-bit shift register plus 2-bit symbol index.
  - Inputs: load, byte_in, advance.
  - Outputs: symbol and last_symbol.
  - Reused for the sync word halves, the header and the payload.

Test Plan:
1. PREAMBLE_SYMS = 4, frame_len = 2, bytes 0xA5 then 0x3C presented immediately, mod_req pulsed every 100 clk -> symbol sequence:
   - preamble 00,11,00,11
   - sync 11,01,00,11,10,01,00,01
   - header 00,00,00,10
   - payload 10,10,01,01, 00,11,11,00
   - done pulses once, the cycle after the 24th mod_req; symbol_en then 0.
2. frame_len = 0 -> exactly 16 symbols (header 00,00,00,00); byte_ready never asserts; done after the 16th mod_req.
3. frame_len = 3, only one byte supplied -> underrun pulses the cycle after the mod_req consuming that byte's 4th symbol; busy = 0; done never asserts.
4. start asserted again mid-SYNC -> ignored, sequence unchanged. start and mod_req coincident in IDLE -> first symbol 2'b00 still held until the next mod_req.
5. reset raised mid-PAYLOAD (between clock edges) -> all outputs reach reset values without waiting for clk. A subsequent frame with frame_len = 1, byte 0xFF ends with symbols 11,11,11,11 and done.
6. Loopback with qpsk_modulator (100 MHz, SYMBOL_RATE 1 MHz), frame_len = 64, byte_valid toggled every other cycle -> no underrun, 64 bytes accepted, done asserted once, mod_req count = PREAMBLE_SYMS + 12 + 256.
